// File: rtl/axi4l_mem_master.sv
// AXI4-Lite load/store master for the mriscvcore execute stage.
// Takes one load or store per transaction. Builds byte strobes and lane-replicated
// write data, and returns load data extended with sign or zero.
// Reports misalignment, bus error responses and a response timeout.
module axi4l_mem_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                W_R,
  input  logic [1:0]          wordsize,
  input  logic                signo,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [2:0]          prot,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                done,
  output logic                misaligned,
  output logic                bus_err,
  output logic                timeout_err,
  output logic [ADDR_W-1:0]   AWaddr,
  output logic                AWvalid,
  output logic [2:0]          AWprot,
  input  logic                AWready,
  output logic [DATA_W-1:0]   Wdata,
  output logic [DATA_W/8-1:0] Wstrb,
  output logic                Wvalid,
  input  logic                Wready,
  input  logic                Bvalid,
  input  logic [1:0]          Bresp,
  output logic                Bready,
  output logic [ADDR_W-1:0]   ARaddr,
  output logic                ARvalid,
  output logic [2:0]          ARprot,
  input  logic                ARready,
  input  logic                Rvalid,
  input  logic [1:0]          Rresp,
  input  logic [DATA_W-1:0]   Rdata,
  output logic                RReady
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int LANE_W  = $clog2(STRB_W);
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Strobe pattern for an access of 1<<ws bytes, before the lane shift
  function automatic logic [STRB_W-1:0] strb_base(input logic [1:0] ws);
    case (ws)
      2'b00:   return STRB_W'(8'h01);
      2'b01:   return STRB_W'(8'h03);
      2'b10:   return STRB_W'(8'h0F);
      2'b11:   return STRB_W'(8'hFF);
      default: return STRB_W'(8'h00);
    endcase
  endfunction

  // Copy the right-aligned store value into every lane of its size
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] wd, input logic [1:0] ws);
    case (ws)
      2'b00:   return {(DATA_W/8){wd[7:0]}};
      2'b01:   return {(DATA_W/16){wd[15:0]}};
      2'b10:   return {(DATA_W/32){wd[31:0]}};
      default: return wd;
    endcase
  endfunction

  // Zero- or sign-extend a right-aligned load field of 1<<ws bytes
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] field,
                                                    input logic [1:0] ws, input logic sgn);
    logic [DATA_W-1:0] mask;
    logic              sbit;
    case (ws)
      2'b00:   begin mask = DATA_W'(8'hFF);          sbit = field[7];        end
      2'b01:   begin mask = DATA_W'(16'hFFFF);       sbit = field[15];       end
      2'b10:   begin mask = DATA_W'(32'hFFFF_FFFF);  sbit = field[31];       end
      default: begin mask = {DATA_W{1'b1}};          sbit = field[DATA_W-1]; end
    endcase
    return (field & mask) | ((sgn & sbit) ? ~mask : {DATA_W{1'b0}});
  endfunction

  // Address not a multiple of the access size, or a double access on a 32-bit bus
  function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] ws);
    case (ws)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return |a[1:0];
      2'b11:   return (DATA_W == 32) || (|a[2:0]);
      default: return 1'b1;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [1:0]          ws_q, ws_d;
  logic                signo_q, signo_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mis_q, mis_d;
  logic                berr_q, berr_d;
  logic                terr_q, terr_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic                aw_valid_q, aw_valid_d;
  logic                ar_valid_q, ar_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                b_ready_q, b_ready_d;
  logic                r_ready_q, r_ready_d;
  logic [2:0]          aw_prot_q, aw_prot_d;
  logic [2:0]          ar_prot_q, ar_prot_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;

  logic [CNT_W-1:0]    cnt_inc_s;
  logic                timed_out_s;
  logic                aw_pend_s;
  logic                w_pend_s;
  logic                misal_s;
  logic [DATA_W-1:0]   rfield_s;

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    ws_d       = ws_q;
    signo_d    = signo_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    berr_d     = berr_q;
    terr_d     = terr_q;
    aw_addr_d  = aw_addr_q;
    ar_addr_d  = ar_addr_q;
    aw_valid_d = aw_valid_q;
    ar_valid_d = ar_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    aw_prot_d  = aw_prot_q;
    ar_prot_d  = ar_prot_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;

    cnt_inc_s   = cnt_q + CNT_W'(1);
    // A dead slave is cut off after TIMEOUT busy cycles; a real handshake in that cycle still wins
    timed_out_s = (TO_LIMIT != {CNT_W{1'b0}}) && (cnt_inc_s == TO_LIMIT);
    aw_pend_s   = aw_valid_q & ~AWready;
    w_pend_s    = w_valid_q & ~Wready;
    misal_s     = is_misaligned(addr[2:0], wordsize);
    rfield_s    = Rdata >> {lane_q, 3'b000};

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          lane_d  = addr[LANE_W-1:0];
          ws_d    = wordsize;
          signo_d = signo;
          cnt_d   = {CNT_W{1'b0}};
          rdata_d = {DATA_W{1'b0}};
          mis_d   = misal_s;
          berr_d  = 1'b0;
          terr_d  = 1'b0;
          if (misal_s) begin
            state_d  = S_DONE;
            w_strb_d = {STRB_W{1'b0}};
            w_data_d = {DATA_W{1'b0}};
          end else if (W_R) begin
            state_d    = S_WADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = addr;
            aw_prot_d  = prot;
            w_strb_d   = strb_base(wordsize) << addr[LANE_W-1:0];
            w_data_d   = replicate(wdata, wordsize);
          end else begin
            state_d    = S_RADDR;
            ar_valid_d = 1'b1;
            ar_addr_d  = addr;
            ar_prot_d  = prot;
            w_strb_d   = {STRB_W{1'b0}};
            w_data_d   = {DATA_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WADDR: begin
        cnt_d = cnt_inc_s;
        if (!aw_pend_s && !w_pend_s) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b0;
          b_ready_d  = 1'b1;
          state_d    = S_WRESP;
        end else if (timed_out_s) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b0;
          terr_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          aw_valid_d = aw_pend_s;
          w_valid_d  = w_pend_s;
        end
      end
      S_WRESP: begin
        cnt_d = cnt_inc_s;
        if (Bvalid) begin
          b_ready_d = 1'b0;
          berr_d    = |Bresp;
          state_d   = S_DONE;
        end else if (timed_out_s) begin
          b_ready_d = 1'b0;
          terr_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WRESP;
        end
      end
      S_RADDR: begin
        cnt_d = cnt_inc_s;
        if (ARready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RDATA;
        end else if (timed_out_s) begin
          ar_valid_d = 1'b0;
          terr_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_RADDR;
        end
      end
      S_RDATA: begin
        cnt_d = cnt_inc_s;
        if (Rvalid) begin
          r_ready_d = 1'b0;
          berr_d    = |Rresp;
          rdata_d   = (|Rresp) ? {DATA_W{1'b0}} : extend_load(rfield_s, ws_q, signo_q);
          state_d   = S_DONE;
        end else if (timed_out_s) begin
          r_ready_d = 1'b0;
          terr_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        aw_valid_d = 1'b0;
        ar_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        b_ready_d  = 1'b0;
        r_ready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == S_WADDR) || (state_d == S_WRESP) ||
             (state_d == S_RADDR) || (state_d == S_RDATA);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; synchronous active-low reset abandons any transaction
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      lane_q     <= {LANE_W{1'b0}};
      ws_q       <= 2'b00;
      signo_q    <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      terr_q     <= 1'b0;
      aw_addr_q  <= {ADDR_W{1'b0}};
      ar_addr_q  <= {ADDR_W{1'b0}};
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_prot_q  <= 3'b000;
      ar_prot_q  <= 3'b000;
      w_data_q   <= {DATA_W{1'b0}};
      w_strb_q   <= {STRB_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      ws_q       <= ws_d;
      signo_q    <= signo_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
      terr_q     <= terr_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      aw_valid_q <= aw_valid_d;
      ar_valid_q <= ar_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      aw_prot_q  <= aw_prot_d;
      ar_prot_q  <= ar_prot_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign misaligned  = mis_q;
  assign bus_err     = berr_q;
  assign timeout_err = terr_q;
  assign AWaddr      = aw_addr_q;
  assign AWvalid     = aw_valid_q;
  assign AWprot      = aw_prot_q;
  assign Wdata       = w_data_q;
  assign Wstrb       = w_strb_q;
  assign Wvalid      = w_valid_q;
  assign Bready      = b_ready_q;
  assign ARaddr      = ar_addr_q;
  assign ARvalid     = ar_valid_q;
  assign ARprot      = ar_prot_q;
  assign RReady      = r_ready_q;

endmodule

// File: tb/tb_axi4l_mem_master.sv
// Directed bench for axi4l_mem_master: a 32-bit and a 64-bit instance share all
// inputs; each vector observes one of them through a selector.
module tb_axi4l_mem_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable, W_R, signo;
  logic [1:0]  wordsize;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [2:0]  prot;
  logic        AWready, Wready, ARready, Bvalid, Rvalid;
  logic [1:0]  Bresp, Rresp;
  logic [63:0] Rdata;

  logic [31:0] a_rdata, a_AWaddr, a_ARaddr, a_Wdata;
  logic [3:0]  a_Wstrb;
  logic        a_busy, a_done, a_mis, a_berr, a_terr;
  logic        a_AWvalid, a_ARvalid, a_Wvalid, a_Bready, a_RReady;
  logic [2:0]  a_AWprot, a_ARprot;

  logic [63:0] b_rdata, b_Wdata;
  logic [31:0] b_AWaddr, b_ARaddr;
  logic [7:0]  b_Wstrb;
  logic        b_busy, b_done, b_mis, b_berr, b_terr;
  logic        b_AWvalid, b_ARvalid, b_Wvalid, b_Bready, b_RReady;
  logic [2:0]  b_AWprot, b_ARprot;

  always #5 clk = ~clk;

  axi4l_mem_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) u32 (
    .clk(clk), .rstn(rstn), .enable(enable), .W_R(W_R), .wordsize(wordsize),
    .signo(signo), .addr(addr), .wdata(wdata[31:0]), .prot(prot),
    .rdata(a_rdata), .busy(a_busy), .done(a_done), .misaligned(a_mis),
    .bus_err(a_berr), .timeout_err(a_terr),
    .AWaddr(a_AWaddr), .AWvalid(a_AWvalid), .AWprot(a_AWprot), .AWready(AWready),
    .Wdata(a_Wdata), .Wstrb(a_Wstrb), .Wvalid(a_Wvalid), .Wready(Wready),
    .Bvalid(Bvalid), .Bresp(Bresp), .Bready(a_Bready),
    .ARaddr(a_ARaddr), .ARvalid(a_ARvalid), .ARprot(a_ARprot), .ARready(ARready),
    .Rvalid(Rvalid), .Rresp(Rresp), .Rdata(Rdata[31:0]), .RReady(a_RReady));

  axi4l_mem_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) u64 (
    .clk(clk), .rstn(rstn), .enable(enable), .W_R(W_R), .wordsize(wordsize),
    .signo(signo), .addr(addr), .wdata(wdata), .prot(prot),
    .rdata(b_rdata), .busy(b_busy), .done(b_done), .misaligned(b_mis),
    .bus_err(b_berr), .timeout_err(b_terr),
    .AWaddr(b_AWaddr), .AWvalid(b_AWvalid), .AWprot(b_AWprot), .AWready(AWready),
    .Wdata(b_Wdata), .Wstrb(b_Wstrb), .Wvalid(b_Wvalid), .Wready(Wready),
    .Bvalid(Bvalid), .Bresp(Bresp), .Bready(b_Bready),
    .ARaddr(b_ARaddr), .ARvalid(b_ARvalid), .ARprot(b_ARprot), .ARready(ARready),
    .Rvalid(Rvalid), .Rresp(Rresp), .Rdata(Rdata), .RReady(b_RReady));

  logic        sel;
  logic [63:0] o_rdata, o_Wdata;
  logic [31:0] o_AWaddr, o_ARaddr;
  logic [7:0]  o_Wstrb;
  logic [2:0]  o_ARprot;
  logic        o_busy, o_done, o_mis, o_berr, o_terr;
  logic        o_AWvalid, o_ARvalid, o_Wvalid, o_Bready, o_RReady;

  // View of whichever instance the current vector targets
  always_comb begin
    o_rdata   = sel ? b_rdata   : {32'h0, a_rdata};
    o_Wdata   = sel ? b_Wdata   : {32'h0, a_Wdata};
    o_Wstrb   = sel ? b_Wstrb   : {4'h0, a_Wstrb};
    o_AWaddr  = sel ? b_AWaddr  : a_AWaddr;
    o_ARaddr  = sel ? b_ARaddr  : a_ARaddr;
    o_ARprot  = sel ? b_ARprot  : a_ARprot;
    o_busy    = sel ? b_busy    : a_busy;
    o_done    = sel ? b_done    : a_done;
    o_mis     = sel ? b_mis     : a_mis;
    o_berr    = sel ? b_berr    : a_berr;
    o_terr    = sel ? b_terr    : a_terr;
    o_AWvalid = sel ? b_AWvalid : a_AWvalid;
    o_ARvalid = sel ? b_ARvalid : a_ARvalid;
    o_Wvalid  = sel ? b_Wvalid  : a_Wvalid;
    o_Bready  = sel ? b_Bready  : a_Bready;
    o_RReady  = sel ? b_RReady  : a_RReady;
  end

  typedef struct {
    logic        sel;
    logic        wr;
    logic [1:0]  ws;
    logic        sg;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rbus;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          e_lat;
    logic        e_mis;
    logic        e_berr;
    logic [63:0] e_rdata;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic        saw_valid, saw_ready, w2, aw2, hs_at_done, busy_at_done;
  logic [7:0]  obs_strb;
  logic [63:0] obs_wdata;
  logic [31:0] obs_awaddr, obs_araddr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Drive one request, model the slave, and watch the selected instance until done
  task automatic run(input vec_t v, input int aw_hold, input logic r_never, output int lat);
    repeat (3) @(negedge clk);
    sel = v.sel; W_R = v.wr; wordsize = v.ws; signo = v.sg; addr = v.addr;
    wdata = v.wd; Rdata = v.rbus; Rresp = v.rresp; Bresp = v.bresp; prot = 3'b010;
    AWready = (aw_hold == 0); Wready = 1'b1; ARready = 1'b1; Bvalid = 1'b1;
    Rvalid = ~r_never;
    saw_valid = 1'b0; saw_ready = 1'b0; w2 = 1'b0; aw2 = 1'b0;
    hs_at_done = 1'b0; busy_at_done = 1'b0;
    obs_strb = 8'h0; obs_wdata = 64'h0; obs_awaddr = 32'h0; obs_araddr = 32'h0;
    lat = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      saw_valid = saw_valid | o_AWvalid | o_Wvalid | o_ARvalid;
      if (o_AWvalid) begin
        obs_strb = o_Wstrb; obs_wdata = o_Wdata; obs_awaddr = o_AWaddr;
      end
      if (o_ARvalid) obs_araddr = o_ARaddr;
      if (c == 2) begin w2 = o_Wvalid; aw2 = o_AWvalid; end
      if (o_Bready | o_RReady) saw_ready = 1'b1;
      if (o_done) begin
        lat = c;
        hs_at_done = o_AWvalid | o_Wvalid | o_ARvalid | o_Bready | o_RReady;
        busy_at_done = o_busy;
        break;
      end
      if (c == aw_hold) AWready = 1'b1;
    end
    if (lat == 0) begin
      total_cnt++;
      $display("FAIL done_wait: got no done within 40 cycles required done");
    end
  endtask

  int lat;
  vec_t sv;

  initial begin
    //          sel  wr   ws     sg   addr          wd                      rbus                    rr     br     lat mis  berr  e_rdata                 strb   e_wdata
    tbl[0]  = '{1'b0,1'b1,2'b10,1'b0,32'h10,64'hDEAD_BEEF,            64'h0,                  2'b00,2'b00,3,1'b0,1'b0,64'h0,                  8'h0F,64'hDEAD_BEEF};
    tbl[1]  = '{1'b0,1'b0,2'b00,1'b1,32'h13,64'h0,                    64'h80FF_0000,          2'b00,2'b00,3,1'b0,1'b0,64'hFFFF_FF80,          8'h00,64'h0};
    tbl[2]  = '{1'b0,1'b0,2'b00,1'b0,32'h13,64'h0,                    64'h80FF_0000,          2'b00,2'b00,3,1'b0,1'b0,64'h0000_0080,          8'h00,64'h0};
    tbl[3]  = '{1'b0,1'b1,2'b01,1'b0,32'h06,64'hABCD_1234,            64'h0,                  2'b00,2'b00,3,1'b0,1'b0,64'h0,                  8'h0C,64'h1234_1234};
    tbl[4]  = '{1'b0,1'b0,2'b10,1'b0,32'h02,64'h0,                    64'h0,                  2'b00,2'b00,1,1'b1,1'b0,64'h0,                  8'h00,64'h0};
    tbl[5]  = '{1'b0,1'b0,2'b11,1'b0,32'h00,64'h0,                    64'h0,                  2'b00,2'b00,1,1'b1,1'b0,64'h0,                  8'h00,64'h0};
    tbl[6]  = '{1'b0,1'b1,2'b00,1'b0,32'h21,64'h5A,                   64'h0,                  2'b00,2'b00,3,1'b0,1'b0,64'h0,                  8'h02,64'h5A5A_5A5A};
    tbl[7]  = '{1'b0,1'b0,2'b01,1'b1,32'h1A,64'h0,                    64'h8001_7FFF,          2'b00,2'b00,3,1'b0,1'b0,64'hFFFF_8001,          8'h00,64'h0};
    tbl[8]  = '{1'b0,1'b1,2'b10,1'b0,32'h30,64'h1122_3344,            64'h0,                  2'b00,2'b10,3,1'b0,1'b1,64'h0,                  8'h0F,64'h1122_3344};
    tbl[9]  = '{1'b0,1'b0,2'b01,1'b0,32'h05,64'h0,                    64'h0,                  2'b00,2'b00,1,1'b1,1'b0,64'h0,                  8'h00,64'h0};
    tbl[10] = '{1'b0,1'b0,2'b10,1'b1,32'h04,64'h0,                    64'h1234_5678,          2'b00,2'b00,3,1'b0,1'b0,64'h1234_5678,          8'h00,64'h0};
    tbl[11] = '{1'b1,1'b0,2'b11,1'b0,32'h08,64'h0,                    64'h0123_4567_89AB_CDEF,2'b00,2'b00,3,1'b0,1'b0,64'h0123_4567_89AB_CDEF,8'h00,64'h0};
    tbl[12] = '{1'b1,1'b1,2'b00,1'b0,32'h05,64'hA7,                   64'h0,                  2'b00,2'b00,3,1'b0,1'b0,64'h0,                  8'h20,64'hA7A7_A7A7_A7A7_A7A7};
    tbl[13] = '{1'b1,1'b0,2'b10,1'b1,32'h0C,64'h0,                    64'h8000_0001_DEAD_BEEF,2'b00,2'b00,3,1'b0,1'b0,64'hFFFF_FFFF_8000_0001,8'h00,64'h0};
    tbl[14] = '{1'b1,1'b0,2'b01,1'b0,32'h0E,64'h0,                    64'hBEEF_0000_0000_0000,2'b00,2'b00,3,1'b0,1'b0,64'h0000_0000_0000_BEEF,8'h00,64'h0};
    tbl[15] = '{1'b1,1'b1,2'b11,1'b0,32'h10,64'h0102_0304_0506_0708,  64'h0,                  2'b00,2'b00,3,1'b0,1'b0,64'h0,                  8'hFF,64'h0102_0304_0506_0708};

    rstn = 1'b0; enable = 1'b0; W_R = 1'b0; signo = 1'b0; wordsize = 2'b00;
    addr = 32'h0; wdata = 64'h0; prot = 3'b000; sel = 1'b0;
    AWready = 1'b0; Wready = 1'b0; ARready = 1'b0; Bvalid = 1'b0; Rvalid = 1'b0;
    Bresp = 2'b00; Rresp = 2'b00; Rdata = 64'h0;
    repeat (3) @(negedge clk);
    chk("reset_outs_32", {63'h0, |{a_rdata, a_busy, a_done, a_mis, a_berr, a_terr, a_AWaddr, a_ARaddr,
        a_AWvalid, a_ARvalid, a_Wvalid, a_Bready, a_RReady, a_AWprot, a_ARprot, a_Wdata, a_Wstrb}}, 64'h0);
    chk("reset_outs_64", {63'h0, |{b_rdata, b_busy, b_done, b_mis, b_berr, b_terr, b_AWaddr, b_ARaddr,
        b_AWvalid, b_ARvalid, b_Wvalid, b_Bready, b_RReady, b_AWprot, b_ARprot, b_Wdata, b_Wstrb}}, 64'h0);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run(tbl[i], 0, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].e_lat));
      chk($sformatf("v%0d_misaligned", i), {63'h0, o_mis}, {63'h0, tbl[i].e_mis});
      chk($sformatf("v%0d_bus_err", i), {63'h0, o_berr}, {63'h0, tbl[i].e_berr});
      chk($sformatf("v%0d_timeout_err", i), {63'h0, o_terr}, 64'h0);
      chk($sformatf("v%0d_rdata", i), o_rdata, tbl[i].e_rdata);
      if (tbl[i].e_mis) begin
        chk($sformatf("v%0d_no_valid", i), {63'h0, saw_valid}, 64'h0);
      end else if (tbl[i].wr) begin
        chk($sformatf("v%0d_wstrb", i), {56'h0, obs_strb}, {56'h0, tbl[i].e_strb});
        chk($sformatf("v%0d_wdata", i), obs_wdata, tbl[i].e_wdata);
        chk($sformatf("v%0d_awaddr", i), {32'h0, obs_awaddr}, {32'h0, tbl[i].addr});
      end else begin
        chk($sformatf("v%0d_araddr", i), {32'h0, obs_araddr}, {32'h0, tbl[i].addr});
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'h0, o_done}, 64'h0);
      chk($sformatf("v%0d_flag_hold", i), {63'h0, o_mis}, {63'h0, tbl[i].e_mis});
    end

    // Write address stalled while write data is accepted at once
    sv = tbl[3];
    run(sv, 4, 1'b0, lat);
    chk("stall_latency", 64'(lat), 64'd6);
    chk("stall_wvalid_c2", {63'h0, w2}, 64'h0);
    chk("stall_awvalid_c2", {63'h0, aw2}, 64'h1);
    chk("stall_bready_seen", {63'h0, saw_ready}, 64'h1);
    chk("stall_wstrb", {56'h0, obs_strb}, 64'h0C);
    chk("stall_bus_err", {63'h0, o_berr}, 64'h0);

    // Load whose data never arrives: timeout, then a load answered with SLVERR
    sv = tbl[10]; sv.addr = 32'h08;
    run(sv, 0, 1'b1, lat);
    chk("to_latency_window", {63'h0, (lat >= 8) && (lat <= 10)}, 64'h1);
    chk("to_timeout_err", {63'h0, o_terr}, 64'h1);
    chk("to_bus_err", {63'h0, o_berr}, 64'h0);
    chk("to_rready_seen", {63'h0, saw_ready}, 64'h1);
    chk("to_handshake_dropped", {63'h0, hs_at_done}, 64'h0);
    chk("to_busy_at_done", {63'h0, busy_at_done}, 64'h0);
    sv = tbl[10]; sv.addr = 32'h0C; sv.rbus = 64'hFFFF_FFFF; sv.rresp = 2'b10;
    run(sv, 0, 1'b0, lat);
    chk("slverr_latency", 64'(lat), 64'd3);
    chk("slverr_bus_err", {63'h0, o_berr}, 64'h1);
    chk("slverr_rdata", o_rdata, 64'h0);
    chk("slverr_timeout_cleared", {63'h0, o_terr}, 64'h0);

    // Reset asserted while the 64-bit instance waits in RDATA
    repeat (3) @(negedge clk);
    sel = 1'b1; W_R = 1'b0; wordsize = 2'b11; signo = 1'b0; addr = 32'h10; prot = 3'b101;
    ARready = 1'b1; Rvalid = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    chk("rst_seq_arvalid", {63'h0, o_ARvalid}, 64'h1);
    chk("rst_seq_arprot", {61'h0, o_ARprot}, 64'h5);
    repeat (2) @(negedge clk);
    chk("rst_seq_rready", {63'h0, o_RReady}, 64'h1);
    chk("rst_seq_busy", {63'h0, o_busy}, 64'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs_64", {63'h0, |{b_rdata, b_busy, b_done, b_mis, b_berr, b_terr, b_AWaddr, b_ARaddr,
        b_AWvalid, b_ARvalid, b_Wvalid, b_Bready, b_RReady, b_AWprot, b_ARprot, b_Wdata, b_Wstrb}}, 64'h0);
    chk("rst_mid_outs_32", {63'h0, |{a_rdata, a_busy, a_done, a_mis, a_berr, a_terr, a_AWaddr, a_ARaddr,
        a_AWvalid, a_ARvalid, a_Wvalid, a_Bready, a_RReady, a_AWprot, a_ARprot, a_Wdata, a_Wstrb}}, 64'h0);
    rstn = 1'b1;
    run(tbl[11], 0, 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'd3);
    chk("post_rst_rdata", o_rdata, 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
